int_controller: RTL

INT_CONTROLLER -- requirements
Module: int_controller

---
 rtl/int_controller.sv | 100 ++++++++++
 1 files changed

// File: rtl/int_controller.sv
// Vectored interrupt controller: edge-detects four completion lines, latches them as pending
// requests and hands the highest-priority one to the processor through a REQ/SERVICE handshake.
module int_controller #(
    parameter logic [31:0] BASE_ADDR = 32'h00000100,
    parameter logic [31:0] STRIDE    = 32'h00000010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  done,
    input  logic        int_ack,
    input  logic        int_done,
    output logic        interrupt,
    output logic [31:0] int_addr,
    output logic [3:0]  pending,
    output logic        busy,
    output logic [7:0]  irq_count
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StReq     = 2'b01,
        StService = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  done_q;
    logic [3:0]  rise;
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  clr_mask;
    logic [1:0]  cur_id_q, cur_id_d;
    logic [1:0]  first_id;
    logic [7:0]  irq_count_q, irq_count_d;
    logic        interrupt_q;

    assign rise = done & ~done_q;

    always_comb begin
        if (pending_q[0])      first_id = 2'd0;
        else if (pending_q[1]) first_id = 2'd1;
        else if (pending_q[2]) first_id = 2'd2;
        else                   first_id = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            done_q      <= 4'b1111;  // lines already high at release must not fire
            pending_q   <= 4'b0000;
            cur_id_q    <= 2'd0;
            irq_count_q <= 8'd0;
            interrupt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_q      <= done;
            pending_q   <= pending_d;
            cur_id_q    <= cur_id_d;
            irq_count_q <= irq_count_d;
            interrupt_q <= (state_d == StReq);
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        irq_count_d = irq_count_q;
        clr_mask    = 4'b0000;
        unique case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    state_d  = StReq;
                    cur_id_d = first_id;
                end
            end
            StReq: begin
                // int_ack has priority over a simultaneous int_done
                if (int_ack) begin
                    state_d            = StService;
                    clr_mask[cur_id_q] = 1'b1;
                    if (irq_count_q != 8'hFF) irq_count_d = irq_count_q + 8'd1;
                end
            end
            StService: begin
                if (int_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // A fresh edge on the source being cleared keeps its pending bit set
        pending_d = (pending_q & ~clr_mask) | rise;
    end

    always_comb begin
        busy     = (state_q != StIdle);
        int_addr = busy ? (BASE_ADDR + {30'd0, cur_id_q} * STRIDE) : 32'd0;
    end

    assign interrupt = interrupt_q;
    assign pending   = pending_q;
    assign irq_count = irq_count_q;

endmodule
